// File: rtl/actor_port_arbiter_pkg.sv
// Shared types for the actor port arbiter and its round-robin picker.
package actor_port_arbiter_pkg;
  localparam int COUNT_W = 16;
  localparam int OWNER_W = 3;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;
endpackage

// File: rtl/actor_rr_picker.sv
// Combinational round-robin picker: first requester scanning cyclically from last+1.
module actor_rr_picker
  import actor_port_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [OWNER_W-1:0] last,
  output logic [OWNER_W-1:0] pick,
  output logic               valid
);

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!valid && req[j] && (((int'(last) + k) % NUM_SRC) == j)) begin
          pick  = OWNER_W'(j);
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/actor_port_arbiter.sv
// Round-robin, burst-bounded sharing of one consumer FIFO port among NUM_SRC actors.
module actor_port_arbiter
  import actor_port_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_SRC-1:0]         src_REQ,
  input  logic [NUM_SRC*DATA_W-1:0]  src_DATA,
  input  logic [NUM_SRC-1:0]         src_SEND,
  input  logic [NUM_SRC*COUNT_W-1:0] src_COUNT,
  output logic [NUM_SRC-1:0]         src_RDY,
  output logic [NUM_SRC-1:0]         src_ACK,
  output logic [DATA_W-1:0]          dst_DATA,
  output logic                       dst_SEND,
  output logic [COUNT_W-1:0]         dst_COUNT,
  input  logic                       dst_RDY,
  input  logic                       dst_ACK,
  output logic [OWNER_W-1:0]         owner,
  output logic                       busy,
  output logic [31:0]                tokens_total
);

  state_t               state_q, state_d;
  logic [OWNER_W-1:0]   owner_q, last_q, pick;
  logic [BURST_W-1:0]   burst_q;
  logic [31:0]          tokens_q;
  logic                 pick_vld;
  logic [NUM_SRC-1:0]   own_oh;
  logic                 own_req, own_send, accept, grant_exit;

  actor_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .req   (src_REQ),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  // Owner selection is empty outside GRANT, which is what blanks every output there.
  always_comb begin
    own_oh   = '0;
    own_req  = 1'b0;
    own_send = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state_q == ST_GRANT && owner_q == OWNER_W'(i)) begin
        own_oh[i] = 1'b1;
        own_req   = src_REQ[i];
        own_send  = src_SEND[i];
      end
    end
  end

  assign accept     = own_send & dst_RDY;
  assign grant_exit = (state_q == ST_GRANT) &&
                      (!own_req || (accept && ({1'b0, burst_q} + 9'd1 == 9'(MAX_BURST))));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (pick_vld) state_d = ST_GRANT;
      ST_GRANT:   if (grant_exit) state_d = ST_HOLDOFF;
      ST_HOLDOFF: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    src_RDY   = own_oh & {NUM_SRC{dst_RDY}};
    src_ACK   = own_oh & {NUM_SRC{dst_ACK & accept}};
    dst_SEND  = accept;
    dst_DATA  = '0;
    dst_COUNT = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (own_oh[i]) begin
        dst_DATA  = src_DATA[i*DATA_W +: DATA_W];
        dst_COUNT = src_COUNT[i*COUNT_W +: COUNT_W];
      end
    end
    busy         = (state_q == ST_GRANT);
    owner        = busy ? owner_q : '0;
    tokens_total = tokens_q;
  end

  // Burst and token bookkeeping; last is only updated on grant exit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q  <= '0;
      last_q   <= OWNER_W'(NUM_SRC - 1);
      burst_q  <= '0;
      tokens_q <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_vld) begin
        owner_q <= pick;
        burst_q <= '0;
      end
      if (accept) begin
        burst_q  <= burst_q + 8'd1;
        tokens_q <= tokens_q + 32'd1;
      end
      if (grant_exit) last_q <= owner_q;
    end
  end

endmodule

// File: tb/tb_actor_port_arbiter.sv
// Randomized and directed checking of actor_port_arbiter against a cycle-level behavioural model.
module tb_actor_port_arbiter;
  import actor_port_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;
  localparam int CW = 16;

  logic            CLK = 1'b0;
  logic            RESET;
  logic [N-1:0]    src_REQ, src_SEND, src_RDY, src_ACK;
  logic [N*DW-1:0] src_DATA;
  logic [N*CW-1:0] src_COUNT;
  logic [DW-1:0]   dst_DATA;
  logic            dst_SEND, dst_RDY, dst_ACK, busy;
  logic [CW-1:0]   dst_COUNT;
  logic [2:0]      owner;
  logic [31:0]     tokens_total;

  actor_port_arbiter #(.NUM_SRC(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .CLK(CLK), .RESET(RESET),
    .src_REQ(src_REQ), .src_DATA(src_DATA), .src_SEND(src_SEND), .src_COUNT(src_COUNT),
    .src_RDY(src_RDY), .src_ACK(src_ACK),
    .dst_DATA(dst_DATA), .dst_SEND(dst_SEND), .dst_COUNT(dst_COUNT),
    .dst_RDY(dst_RDY), .dst_ACK(dst_ACK),
    .owner(owner), .busy(busy), .tokens_total(tokens_total)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Model: who holds the port (-1 = nobody), pending holdoff, rotation pointer, tokens in burst.
  int          m_owner, m_hold, m_last, m_burst;
  logic [31:0] m_total;

  bit   mon_en;
  bit   prev_busy, seen_burst;
  int   idle_run, burst_tok;
  int   gseq[$], bcnt[$], gaps[$];
  logic [DW-1:0] sentq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = N - 1;
    m_burst = 0;
    m_total = '0;
  endtask

  task automatic check_outputs();
    logic [N-1:0]  e_rdy, e_ack;
    logic          e_send, e_busy;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
    logic [2:0]    e_own;
    e_rdy = '0; e_ack = '0; e_send = 1'b0; e_busy = 1'b0;
    e_data = '0; e_cnt = '0; e_own = '0;
    if (m_owner >= 0) begin
      e_busy = 1'b1;
      e_own  = 3'(m_owner);
      e_rdy[m_owner] = dst_RDY;
      e_send = src_SEND[m_owner] & dst_RDY;
      e_ack[m_owner] = e_send & dst_ACK;
      e_data = src_DATA[m_owner*DW +: DW];
      e_cnt  = src_COUNT[m_owner*CW +: CW];
    end
    chk("src_rdy", src_RDY, e_rdy);
    chk("src_ack", src_ACK, e_ack);
    chk("dst_send", dst_SEND, e_send);
    chk("dst_data", dst_DATA, e_data);
    chk("dst_count", dst_COUNT, e_cnt);
    chk("owner", owner, e_own);
    chk("busy", busy, e_busy);
    chk("tokens_total", tokens_total, m_total);
  endtask

  task automatic model_step();
    if (RESET) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (src_SEND[m_owner] && dst_RDY) begin
        m_burst++;
        m_total = m_total + 32'd1;
      end
      if (!src_REQ[m_owner] || m_burst == MB) begin
        m_last  = m_owner;
        m_owner = -1;
        m_hold  = 1;
      end
    end else if (m_hold != 0) begin
      m_hold = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && src_REQ[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_burst = 0;
        end
      end
    end
  endtask

  task automatic monitor();
    if (dst_SEND) sentq.push_back(dst_DATA);
    if (!mon_en) return;
    if (busy) begin
      if (!prev_busy) begin
        gseq.push_back(int'(owner));
        if (seen_burst) gaps.push_back(idle_run);
        burst_tok = 0;
      end
      if (dst_SEND) burst_tok++;
    end else begin
      if (prev_busy) begin
        bcnt.push_back(burst_tok);
        seen_burst = 1'b1;
        idle_run = 0;
      end
      idle_run++;
    end
    prev_busy = busy;
  endtask

  // One clock: inputs already driven just after a falling edge.
  task automatic tick();
    #1;
    check_outputs();
    monitor();
    model_step();
    @(negedge CLK);
  endtask

  task automatic rnd_data();
    for (int i = 0; i < N; i++) begin
      src_DATA[i*DW +: DW]  = DW'($urandom);
      src_COUNT[i*CW +: CW] = CW'($urandom);
    end
  endtask

  task automatic go_idle();
    src_REQ = '0; src_SEND = '0; dst_RDY = 1'b1; dst_ACK = 1'b1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    model_reset();
    tick();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] t0;
    logic [7:0]  t1_vals [3];
    int          exp_g   [5];
    t1_vals = '{8'h15, 8'h06, 8'h18};
    exp_g   = '{0, 1, 2, 3, 0};
    mon_en = 1'b0; prev_busy = 1'b0; seen_burst = 1'b0; idle_run = 0; burst_tok = 0;
    RESET = 1'b1;
    go_idle();
    rnd_data();
    model_reset();
    @(negedge CLK);
    do_reset();
    chk("rst_tokens", tokens_total, 32'd0);
    chk("rst_busy", busy, 1'b0);

    // Test 1: single owner, three tokens, then release.
    sentq.delete();
    src_REQ = 4'b0001;
    tick();
    chk("t1_owner", owner, 3'd0);
    chk("t1_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      src_SEND = 4'b0001;
      src_DATA[0 +: DW] = t1_vals[i];
      tick();
    end
    src_REQ = '0; src_SEND = '0;
    tick();
    chk("t1_holdoff_busy", busy, 1'b0);
    tick();
    tick();
    chk("t1_tokens", tokens_total, 32'd3);
    chk("t1_nsent", sentq.size(), 3);
    for (int i = 0; i < 3 && i < sentq.size(); i++) chk("t1_data", sentq[i], t1_vals[i]);

    // Test 2: everyone requests and strobes continuously.
    do_reset();
    gseq.delete(); bcnt.delete(); gaps.delete();
    prev_busy = 1'b0; seen_burst = 1'b0; idle_run = 0;
    mon_en = 1'b1;
    src_REQ = 4'b1111; src_SEND = 4'b1111; dst_RDY = 1'b1;
    for (int c = 0; c < 48; c++) begin
      rnd_data();
      tick();
    end
    mon_en = 1'b0;
    go_idle();
    for (int c = 0; c < 4; c++) tick();
    chk("t2_ngrants_ok", gseq.size() >= 5, 1'b1);
    chk("t2_nbursts_ok", bcnt.size() >= 4, 1'b1);
    chk("t2_ngaps_ok", gaps.size() >= 4, 1'b1);
    for (int i = 0; i < 5 && i < gseq.size(); i++) chk("t2_grant_seq", gseq[i], exp_g[i]);
    for (int i = 0; i < 4 && i < bcnt.size(); i++) chk("t2_burst_len", bcnt[i], MB);
    for (int i = 0; i < 4 && i < gaps.size(); i++) chk("t2_gap", gaps[i], 2);

    // Test 3: owner 2 under dst_RDY back-pressure, source 1 strobing out of turn.
    sentq.delete();
    src_REQ = 4'b0100;
    tick();
    chk("t3_owner", owner, 3'd2);
    src_SEND = 4'b0110;
    src_DATA[1*DW +: DW] = 8'hA1;
    for (int i = 0; i < 4; i++) begin
      dst_RDY = (i == 0 || i == 3);
      src_DATA[2*DW +: DW] = 8'(8'h20 + i);
      tick();
    end
    chk("t3_burst_cnt", dut.burst_q, 8'd2);
    go_idle();
    for (int c = 0; c < 3; c++) tick();
    chk("t3_nsent", sentq.size(), 2);
    if (sentq.size() == 2) begin
      chk("t3_data0", sentq[0], 8'h20);
      chk("t3_data1", sentq[1], 8'h23);
    end

    // Test 4: accept coincides with REQ falling.
    t0 = tokens_total;
    src_REQ = 4'b0001;
    tick();
    src_SEND = 4'b0001;
    tick();
    src_REQ = '0;
    src_DATA[0 +: DW] = 8'h44;
    #1;
    chk("t4_ack", src_ACK, 4'b0001);
    chk("t4_send", dst_SEND, 1'b1);
    tick();
    src_SEND = '0;
    chk("t4_holdoff", busy, 1'b0);
    chk("t4_tokens", tokens_total, t0 + 32'd2);
    tick();
    tick();

    // Test 5: reset in the middle of a burst.
    src_REQ = 4'b0010;
    tick();
    src_SEND = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_burst_cnt", dut.burst_q, 8'd5);
    RESET = 1'b1;
    src_REQ = 4'b1111;
    model_reset();
    #1;
    chk("t5_rdy_in_reset", src_RDY, 4'b0000);
    chk("t5_send_in_reset", dst_SEND, 1'b0);
    chk("t5_busy_in_reset", busy, 1'b0);
    tick();
    RESET = 1'b0;
    src_SEND = '0;
    tick();
    chk("t5_first_owner", owner, 3'd0);
    chk("t5_tokens", tokens_total, 32'd0);
    go_idle();
    for (int c = 0; c < 3; c++) tick();

    // Test 6: counter wrap from a preloaded value.
    force dut.tokens_q = 32'hFFFF_FFFE;
    m_total = 32'hFFFF_FFFE;
    tick();
    release dut.tokens_q;
    tick();
    src_REQ = 4'b0001;
    tick();
    src_SEND = 4'b0001;
    tick();
    chk("t6_wrap0", tokens_total, 32'hFFFF_FFFF);
    tick();
    chk("t6_wrap1", tokens_total, 32'h0000_0000);
    tick();
    chk("t6_wrap2", tokens_total, 32'h0000_0001);
    go_idle();
    for (int c = 0; c < 3; c++) tick();

    // Random traffic with sticky requests and occasional reset.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) src_REQ[i] = ~src_REQ[i];
      src_SEND = N'($urandom);
      dst_RDY  = ($urandom_range(3) != 0);
      dst_ACK  = ($urandom_range(7) != 0);
      rnd_data();
      if ($urandom_range(499) == 0) begin
        RESET = 1'b1;
        model_reset();
        tick();
        RESET = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
